// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// PS/2 device-to-host receiver. The raw keyboard clock and data pins are
// synchronized, falling edges of the keyboard clock are detected, and 11-bit
// frames (start, 8 data bits LSB first, odd parity, stop) are recovered.
// Frames that pass the framing and parity checks deliver their scan-code byte
// into a small circular FIFO. The FIFO is read through a valid/ready stream.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (asynchronous to clk)
//   ps2_data   raw PS/2 data pin (asynchronous to clk), never driven here
//   out_ready  consumer accepts the head byte this cycle
//   ovf_clr    clears the sticky overflow flag
//   out_valid  FIFO holds at least one byte
//   out_data   head-of-FIFO scan code
//   count      FIFO occupancy, 0..DEPTH
//   overflow   sticky, a good frame was dropped because the FIFO was full
//   frame_err  one-cycle pulse on a bad start, stop or parity bit
module ps2_kbd_rx #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   input  logic                     out_ready,
   input  logic                     ovf_clr,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     frame_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   // Synchronizer and edge-detect flops. They reset high because an idle
   // PS/2 bus is pulled high, so no false falling edge appears after reset.
   logic clk_s1;
   logic clk_s2;
   logic clk_hist;
   logic data_s1;
   logic data_s2;
   logic fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_hist <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_hist <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
      end
   end

   assign fall = clk_hist & ~clk_s2;

   // Frame receiver state.
   state_t          state;
   state_t          state_nxt;
   logic [2:0]      bit_cnt;
   logic [2:0]      bit_cnt_nxt;
   logic [7:0]      shift;
   logic [7:0]      shift_nxt;
   logic            par_bit;
   logic            par_nxt;
   logic [TW-1:0]   tmo_cnt;
   logic [TW-1:0]   tmo_nxt;
   logic            push_req;
   logic            err_nxt;
   logic            frame_good;

   // A frame is good when the stop bit is high and the data byte together
   // with the parity bit has an odd number of ones.
   assign frame_good = data_s2 & (^{shift, par_bit});

   // Registers of the frame receiver, including the registered error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         par_bit   <= 1'b0;
         tmo_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift     <= shift_nxt;
         par_bit   <= par_nxt;
         tmo_cnt   <= tmo_nxt;
         frame_err <= err_nxt;
      end
   end

   // Next-state logic. Every bit is taken on a detected falling edge of the
   // keyboard clock. Outside IDLE a watchdog counts cycles since the last
   // edge; if the keyboard goes quiet mid-frame the partial frame is dropped
   // silently so the receiver resynchronizes on the next start bit.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      par_nxt     = par_bit;
      tmo_nxt     = '0;
      push_req    = 1'b0;
      err_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (fall) begin
               if (!data_s2) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         DATA: begin
            if (fall) begin
               shift_nxt   = {data_s2, shift[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               par_nxt   = data_s2;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               if (frame_good) begin
                  push_req = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (state != IDLE && !fall) begin
         if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
         end else begin
            tmo_nxt = tmo_cnt + TW'(1);
         end
      end
   end

   // FIFO storage and pointers.
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          full;
   logic          pop;
   logic          do_push;
   logic          ovf_set;

   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign full      = (count == CW'(DEPTH));
   assign pop       = out_valid & out_ready;

   // A good frame arriving at a full FIFO still fits when the head is popped
   // in the same cycle; otherwise it is dropped and flagged as overflow.
   assign do_push   = push_req & (~full | pop);
   assign ovf_set   = push_req & full & ~pop;

   // Storage is cleared on reset so the head reads zero while empty after
   // reset. A byte pushed into an empty FIFO becomes visible the next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= shift;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally because
   // DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag; a new drop wins over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx
// Self-checking bench for ps2_kbd_rx. A keyboard driver bit-bangs PS/2
// frames; a queue-based reference model predicts the FIFO contents, the
// overflow flag and frame_err pulses from the frame rules and the fixed
// three-edge latency, and a compare process checks the DUT every cycle.
// Directed scenarios add literal expectations that pin the model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 10;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic       out_ready = 1'b0;
   logic       ovf_clr   = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic [3:0] count;
   logic       overflow;
   logic       frame_err;

   ps2_kbd_rx #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .out_ready (out_ready),
      .ovf_clr   (ovf_clr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   // 100 MHz system clock.
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit check_en = 0;

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a byte queue plus a list of frame completions that
   // take effect on the third rising clk edge after the stop-bit fall.
   typedef struct {
      int     due;
      bit     is_err;
      bit [7:0] data;
   } ev_t;

   ev_t        events[$];
   logic [7:0] model_q[$];
   bit         model_ovf  = 0;
   bit         model_ferr = 0;
   int         cyc = 0;

   // Model update on each clock edge, cleared by reset at once.
   always @(posedge clk or negedge rst) begin : model_proc
      int  sz;
      bit  pop_now;
      bit  set_ovf;
      ev_t ev;
      if (!rst) begin
         model_q.delete();
         events.delete();
         model_ovf  = 0;
         model_ferr = 0;
      end else begin
         cyc++;
         sz         = model_q.size();
         pop_now    = (sz != 0) && out_ready;
         set_ovf    = 0;
         model_ferr = 0;
         if (pop_now) void'(model_q.pop_front());
         while (events.size() != 0 && events[0].due <= cyc) begin
            ev = events.pop_front();
            if (ev.is_err) model_ferr = 1;
            else if (sz < DEPTH || pop_now) model_q.push_back(ev.data);
            else set_ovf = 1;
         end
         if (set_ovf) model_ovf = 1;
         else if (ovf_clr) model_ovf = 0;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         if (!rst) begin
            checkOutput("rst_valid", out_valid, 0);
            checkOutput("rst_count", count, 0);
            checkOutput("rst_data", out_data, 0);
            checkOutput("rst_overflow", overflow, 0);
            checkOutput("rst_frame_err", frame_err, 0);
         end else begin
            checkOutput("valid", out_valid, model_q.size() != 0);
            checkOutput("count", count, model_q.size());
            if (model_q.size() != 0) checkOutput("data", out_data, model_q[0]);
            checkOutput("overflow", overflow, model_ovf);
            checkOutput("frame_err", frame_err, model_ferr);
         end
      end
   end

   // Observed deliveries and error pulses for the literal checks.
   logic [7:0] popped[$];
   int         ferr_cycles = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) popped.push_back(out_data);
         if (frame_err) ferr_cycles++;
      end
   end

   // Random consumer behaviour used only in the random phase.
   bit rand_en   = 0;
   int ready_pct = 100;

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
         ovf_clr   = ($urandom_range(0, 255) == 0);
      end
   end

   task automatic waitCycles(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One PS/2 bit: data set while the clock is high, then a low phase.
   // A scheduled bit registers a frame completion with the model.
   task automatic ps2Bit(bit b, bit sched, bit is_err, bit [7:0] val, bit ready_pulse);
      ps2_data = b;
      waitCycles(HALF);
      ps2_clk = 1'b0;
      if (sched) events.push_back(ev_t'{cyc + 3, is_err, val});
      for (int i = 1; i <= HALF; i++) begin
         @(posedge clk);
         #1;
         if (ready_pulse && i == 2) out_ready = 1'b1;
         if (ready_pulse && i == 3) out_ready = 1'b0;
      end
      ps2_clk = 1'b1;
   endtask

   // Full frame; par_flip makes parity even, stop_bit=0 breaks framing.
   task automatic applyStimulus(bit [7:0] val, bit par_flip, bit stop_bit, bit ready_pulse);
      bit par  = ~(^val) ^ par_flip;
      bit good = stop_bit && !par_flip;
      ps2Bit(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) ps2Bit(val[i], 1'b0, 1'b0, 8'h00, 1'b0);
      ps2Bit(par, 1'b0, 1'b0, 8'h00, 1'b0);
      ps2Bit(stop_bit, 1'b1, !good, val, ready_pulse);
      ps2_data = 1'b1;
      waitCycles(4);
   endtask

   task automatic partialFrame(int ndata);
      ps2Bit(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < ndata; i++) ps2Bit(i[0], 1'b0, 1'b0, 8'h00, 1'b0);
      ps2_data = 1'b1;
   endtask

   task automatic badStart();
      ps2Bit(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      waitCycles(4);
   endtask

   initial begin
      waitCycles(3);
      check_en = 1;
      waitCycles(2);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_data", out_data, 0);
      rst = 1'b1;
      waitCycles(5);

      // Good frame 0x1C with the consumer ready.
      popped.delete();
      ferr_cycles = 0;
      out_ready = 1'b1;
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      waitCycles(5);
      checkOutput("good_n", popped.size(), 1);
      if (popped.size() > 0) checkOutput("good_byte", popped[0], 8'h1C);
      checkOutput("good_ferr", ferr_cycles, 0);
      checkOutput("good_count", count, 0);

      // Parity error.
      popped.delete();
      ferr_cycles = 0;
      applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
      waitCycles(5);
      checkOutput("par_ferr", ferr_cycles, 1);
      checkOutput("par_n", popped.size(), 0);
      checkOutput("par_count", count, 0);

      // Overflow with nine frames and no consumer.
      out_ready = 1'b0;
      for (int v = 1; v <= 9; v++) applyStimulus(8'(v), 1'b0, 1'b1, 1'b0);
      checkOutput("ovf_count", count, 8);
      checkOutput("ovf_flag", overflow, 1);
      popped.delete();
      out_ready = 1'b1;
      waitCycles(12);
      out_ready = 1'b0;
      checkOutput("ovf_drain_n", popped.size(), 8);
      for (int i = 0; i < 8 && i < popped.size(); i++) checkOutput("ovf_drain_byte", popped[i], i + 1);
      ovf_clr = 1'b1;
      waitCycles(1);
      ovf_clr = 1'b0;
      waitCycles(1);
      checkOutput("ovf_cleared", overflow, 0);

      // Full FIFO with pop and push in the same cycle.
      for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      checkOutput("full_count", count, 8);
      popped.delete();
      applyStimulus(8'hF0, 1'b0, 1'b1, 1'b1);
      checkOutput("simul_count", count, 8);
      checkOutput("simul_ovf", overflow, 0);
      out_ready = 1'b1;
      waitCycles(12);
      out_ready = 1'b0;
      checkOutput("simul_n", popped.size(), 9);
      if (popped.size() == 9) begin
         checkOutput("simul_first", popped[0], 8'h10);
         checkOutput("simul_last", popped[8], 8'hF0);
      end

      // Timeout resync after an abandoned partial frame.
      popped.delete();
      ferr_cycles = 0;
      out_ready = 1'b1;
      partialFrame(4);
      waitCycles(TIMEOUT + 10);
      applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0);
      waitCycles(5);
      checkOutput("tmo_n", popped.size(), 1);
      if (popped.size() > 0) checkOutput("tmo_byte", popped[0], 8'hF0);
      checkOutput("tmo_ferr", ferr_cycles, 0);

      // Asynchronous reset mid-frame with bytes buffered.
      out_ready = 1'b0;
      applyStimulus(8'h33, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h44, 1'b0, 1'b1, 1'b0);
      checkOutput("pre_rst_count", count, 2);
      partialFrame(4);
      rst = 1'b0;
      waitCycles(1);
      checkOutput("mid_rst_count", count, 0);
      checkOutput("mid_rst_valid", out_valid, 0);
      checkOutput("mid_rst_data", out_data, 0);
      waitCycles(3);
      rst = 1'b1;
      waitCycles(3);
      popped.delete();
      ferr_cycles = 0;
      out_ready = 1'b1;
      applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
      waitCycles(5);
      checkOutput("post_rst_n", popped.size(), 1);
      if (popped.size() > 0) checkOutput("post_rst_byte", popped[0], 8'h5A);
      checkOutput("post_rst_ferr", ferr_cycles, 0);

      // Randomized traffic with varying consumer rates and error injection.
      rand_en = 1;
      for (int blk = 0; blk < 4; blk++) begin
         case ($urandom_range(0, 3))
            0:       ready_pct = 0;
            1:       ready_pct = 2;
            2:       ready_pct = 50;
            default: ready_pct = 100;
         endcase
         for (int f = 0; f < 8; f++) begin
            int r = $urandom_range(0, 19);
            bit [7:0] b = 8'($urandom_range(0, 255));
            if (r == 0) badStart();
            else if (r == 1) applyStimulus(b, 1'b1, 1'b1, 1'b0);
            else if (r == 2) applyStimulus(b, 1'b0, 1'b0, 1'b0);
            else applyStimulus(b, 1'b0, 1'b1, 1'b0);
         end
      end
      rand_en = 0;
      waitCycles(2);
      ovf_clr = 1'b0;
      out_ready = 1'b1;
      waitCycles(20);
      checkOutput("final_count", count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #5_000_000;
      fails++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 device-to-host receiver: the stage directly upstream of the board top-level's keyboard logic.
- Consumes the raw ps2_clk/ps2_data board pins and recovers 11-bit frames.
- Checks framing and odd parity, then buffers valid scan-code bytes in a small FIFO.
- Presents the bytes on a valid/ready stream to the display, LED and 7-seg logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 50000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- out_ready  input  1  consumer accepts the head byte.
- ovf_clr  input  1  clears the sticky overflow flag.
- out_valid  output  1  FIFO non-empty.
- out_data  output  8  head-of-FIFO scan code.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad start, stop or parity bit.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, bit counter=0, shift register=0, FIFO empty, count=0, out_valid=0, out_data=0, overflow=0, frame_err=0; synchronizer flops set to 1 (bus idle-high).
- Synchronization and edge detect:
  - ps2_clk passes two sync flops plus one history flop; fall = hist & ~sync2.
  - ps2_data passes two sync flops and is sampled only in a cycle where fall=1.
- FSM, all transitions on fall unless noted:
  - IDLE: a sampled bit of 0 (start) -> DATA, bitcnt=0. A sampled 1 stays IDLE and pulses frame_err.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: evaluate the frame, then -> IDLE. Good = stop bit is 1 AND (XOR of data ^ parity) == 1.
    - Good frame: push the byte.
    - Bad frame: pulse frame_err for 1 cycle, no push.
- Timeout: in any state other than IDLE, a cycle counter runs and is reset on every fall.
  - When it reaches TIMEOUT-1 the FSM returns to IDLE and the partial frame is discarded.
  - No frame_err, no push.
- Latency: out_valid rises 3 clk rising edges after the raw ps2_clk falling edge of the stop bit, when the FIFO was empty.
- FIFO: circular buffer with wrapping read/write pointers.
  - out_data = mem[rd_ptr], combinational from registered state.
  - Pop when out_valid & out_ready.
  - Push of a good frame when not full.
- Push while full:
  - With a pop in the same cycle, both happen; count unchanged, no overflow.
  - Without a pop, the byte is dropped and overflow is set to 1.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Pop while empty is ignored.
- Push into an empty FIFO with out_ready=1: the byte is visible the next cycle, not bypassed.
- count: +1 on push only, -1 on pop only, unchanged when both or neither; never exceeds DEPTH.
- Reset mid-frame or with FIFO content: everything returns to reset values immediately; no spurious push after release.
- ps2_data is never driven; this block is receive-only.

Test Plan:
- Good frame: send start 0, byte 0x1C LSB first (0,0,1,1,1,0,0,0), parity 0, stop 1, with ready=1 -> out_valid pulses 1 cycle, out_data=0x1C, frame_err stays 0, count returns to 0.
- Parity error: send 0x1C with parity 1 -> frame_err high exactly 1 cycle after the stop fall, out_valid stays 0, count=0.
- Overflow: hold ready=0 and send 9 good frames 0x01..0x09 -> count=8, overflow=1 after the 9th.
  - Then ready=1 -> drains 0x01..0x08 in order and 0x09 never appears.
  - Pulse ovf_clr -> overflow=0.
- Full with simultaneous pop/push: FIFO full of 0x10..0x17, assert ready in the cycle the stop bit of 0xF0 is accepted -> count stays 8, overflow=0, 0xF0 emerges as the 8th byte afterwards.
- Timeout resync: send a start bit plus 4 data bits, idle for TIMEOUT+10 cycles, then a full frame 0xF0 -> only 0xF0 is delivered, frame_err=0.
- Async reset mid-frame: assert rst=0 after 5 bits with 2 bytes buffered, release, send 0x5A -> count=0 and outputs zero during reset; the only byte delivered afterwards is 0x5A.
